// File: rtl/v2f_mul_pkg.sv
// Shared constants, state type and limb helper for the sequential 64x64 multiplier.
package v2f_mul_pkg;

  localparam int unsigned LIMB_W     = 16;
  localparam int unsigned NUM_LIMBS  = 4;
  localparam int unsigned STEPS_LOW  = 10;
  localparam int unsigned STEPS_FULL = 16;

  localparam int unsigned IDX_W   = 2;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned SHIFT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Select 16-bit limb idx of a 64-bit operand.
  function automatic logic [LIMB_W-1:0] limb_sel(input logic [63:0] v,
                                                 input logic [IDX_W-1:0] idx);
    logic [LIMB_W-1:0] r;
    case (idx)
      2'd0:    r = v[15:0];
      2'd1:    r = v[31:16];
      2'd2:    r = v[47:32];
      default: r = v[63:48];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/v2f_mul_limb_sched.sv
// Limb-pair scheduler: walks (i,j) with i outer, j inner, optionally skipping
// pairs whose partial product lands entirely above bit 63.
module v2f_mul_limb_sched
  import v2f_mul_pkg::*;
#(
  parameter bit LOW_ONLY = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               advance_i,
  output logic [IDX_W-1:0]   i_o,
  output logic [IDX_W-1:0]   j_o,
  output logic [SHIFT_W-1:0] shift_o,
  output logic               last_o
);

  localparam logic [STEP_W-1:0] LAST_STEP =
    LOW_ONLY ? STEP_W'(STEPS_LOW - 1) : STEP_W'(STEPS_FULL - 1);

  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [IDX_W:0]    ij_sum;
  logic              row_end;

  assign ij_sum = {1'b0, i_q} + {1'b0, j_q};

  // In low-only mode a row ends on the anti-diagonal i+j==3 instead of j==3.
  assign row_end = LOW_ONLY ? (ij_sum == 3'd3) : (j_q == 2'd3);

  // Next-index computation: restart on start, step on advance.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    step_d = step_q;
    if (start_i) begin
      i_d    = '0;
      j_d    = '0;
      step_d = '0;
    end else if (advance_i) begin
      step_d = step_q + 1'b1;
      if (row_end) begin
        i_d = i_q + 1'b1;
        j_d = '0;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  // Index and step registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q    <= '0;
      j_q    <= '0;
      step_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      step_q <= step_d;
    end
  end

  assign i_o     = i_q;
  assign j_o     = j_q;
  assign shift_o = {ij_sum, 4'b0000};
  assign last_o  = (step_q == LAST_STEP);

endmodule

// File: rtl/v2f_mul64_seq.sv
// Sequential 64x64 multiplier controller driving one shared external 16x16
// multiplier; operands in and product out over valid/ready handshakes.
module v2f_mul64_seq
  import v2f_mul_pkg::*;
#(
  parameter bit LOW_ONLY = 1'b1
) (
  input  logic         CLK,
  input  logic         ARST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  A,
  input  logic [63:0]  B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] Y,
  output logic [15:0]  mul_a,
  output logic [15:0]  mul_b,
  input  logic [31:0]  mul_p
);

  state_e               state_q, state_d;
  logic [63:0]          a_q, a_d, b_q, b_d;
  logic [127:0]         acc_q, acc_d;
  logic                 issue_q, issue_d;
  logic                 pv_q, pv_d;
  logic [31:0]          prod_q, prod_d;
  logic [SHIFT_W-1:0]   sh_q, sh_d;

  logic                 accept;
  logic                 advance;
  logic [IDX_W-1:0]     sched_i, sched_j;
  logic [SHIFT_W-1:0]   sched_shift;
  logic                 sched_last;

  assign accept  = (state_q == ST_IDLE) && in_valid;
  assign advance = (state_q == ST_CALC) && issue_q;

  v2f_mul_limb_sched #(
    .LOW_ONLY (LOW_ONLY)
  ) u_sched (
    .clk_i     (CLK),
    .rst_i     (ARST),
    .start_i   (accept),
    .advance_i (advance),
    .i_o       (sched_i),
    .j_o       (sched_j),
    .shift_o   (sched_shift),
    .last_o    (sched_last)
  );

  // Control and datapath next state.
  // The external product is registered with its shift before being added, so
  // the 128-bit adder never sits behind the shared multiplier's combinational
  // path; CALC therefore holds one drain cycle after the last limb is issued.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    issue_d = issue_q;
    pv_d    = pv_q;
    prod_d  = prod_q;
    sh_d    = sh_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          issue_d = 1'b1;
          pv_d    = 1'b0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (issue_q) begin
          prod_d = mul_p;
          sh_d   = sched_shift;
          pv_d   = 1'b1;
          if (sched_last) begin
            issue_d = 1'b0;
          end
        end else begin
          pv_d = 1'b0;
        end
        if (pv_q) begin
          acc_d = acc_q + ({96'b0, prod_q} << sh_q);
        end
        if (!issue_q && pv_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      issue_q <= 1'b0;
      pv_q    <= 1'b0;
      prod_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      issue_q <= issue_d;
      pv_q    <= pv_d;
      prod_q  <= prod_d;
      sh_q    <= sh_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    mul_a     = '0;
    mul_b     = '0;
    Y         = '0;
    if (advance) begin
      mul_a = limb_sel(a_q, sched_i);
      mul_b = limb_sel(b_q, sched_j);
    end
    if (state_q == ST_DONE) begin
      Y = {(LOW_ONLY ? 64'b0 : acc_q[127:64]), acc_q[63:0]};
    end
  end

endmodule

// File: tb/tb_v2f_mul64_seq.sv
// Self-checking bench for v2f_mul64_seq: one low-only and one full instance,
// each with its own behavioural 16x16 multiplier.
module tb_v2f_mul64_seq;

  logic         clk = 1'b0;
  logic         arst;
  logic [1:0]   iv, ordy, irdy, ov;
  logic [63:0]  a_in [2];
  logic [63:0]  b_in [2];
  logic [127:0] y    [2];
  logic [15:0]  ma   [2];
  logic [15:0]  mb   [2];
  logic [31:0]  mp   [2];

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assign mp[0] = {16'b0, ma[0]} * {16'b0, mb[0]};
  assign mp[1] = {16'b0, ma[1]} * {16'b0, mb[1]};

  v2f_mul64_seq #(.LOW_ONLY(1'b1)) u_low (
    .CLK(clk), .ARST(arst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .A(a_in[0]), .B(b_in[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .Y(y[0]), .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp[0])
  );

  v2f_mul64_seq #(.LOW_ONLY(1'b0)) u_full (
    .CLK(clk), .ARST(arst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .A(a_in[1]), .B(b_in[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .Y(y[1]), .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp[1])
  );

  // Reference: exact unsigned product, top half cleared in low-only mode.
  function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                            input bit full);
    logic [127:0] p;
    p = {64'b0, a} * {64'b0, b};
    if (!full) p[127:64] = '0;
    return p;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Present operands at a negedge; the following posedge is the accept edge.
  task automatic accept(input int d, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    a_in[d] = a;
    b_in[d] = b;
    iv[d]   = 1'b1;
    @(posedge clk);
    #1 iv[d] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(input int d, input int maxc, output int edges, output bit saw_ready);
    edges = 0;
    saw_ready = 1'b0;
    while (edges < maxc) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ov[d]) break;
      if (irdy[d]) saw_ready = 1'b1;
    end
  endtask

  task automatic handshake(input int d);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1 ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (irdy[d] !== 1'b1 || ov[d] !== 1'b0 || y[d] !== '0 || ma[d] !== '0 || mb[d] !== '0) begin
        failures++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b Y=%h mul_a=%h mul_b=%h, want 1 0 0 0 0",
                 d, irdy[d], ov[d], y[d], ma[d], mb[d]);
      end
    end
    iv = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (irdy !== 2'b11 || ov !== 2'b00) begin
      failures++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b, want 11 00", irdy, ov);
    end
    iv = 2'b00;
    arst = 1'b0;
  endtask

  task automatic test_basic();
    int e; bit sr;
    accept(0, 64'd3, 64'd5);
    wait_done(0, 30, e, sr);
    checks++;
    if (ov[0] !== 1'b1 || e != 11) begin
      failures++;
      $display("FAIL basic_latency: out_valid=%b edges=%0d, want 1 after 11", ov[0], e);
    end
    checks++;
    if (sr) begin
      failures++;
      $display("FAIL basic_in_ready: in_ready seen 1 during operation, want 0");
    end
    checks++;
    if (y[0] !== 128'd15) begin
      failures++;
      $display("FAIL basic_Y: got %h want %h", y[0], 128'd15);
    end
    handshake(0);
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b1 || y[0] !== '0) begin
      failures++;
      $display("FAIL basic_idle: out_valid=%b in_ready=%b Y=%h, want 0 1 0", ov[0], irdy[0], y[0]);
    end
  endtask

  task automatic test_all_ones();
    int e; bit sr;
    logic [127:0] exp_full;
    exp_full = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    accept(0, '1, '1);
    wait_done(0, 30, e, sr);
    checks++;
    if (ov[0] !== 1'b1 || y[0] !== 128'h1) begin
      failures++;
      $display("FAIL ones_low: out_valid=%b Y=%h want 1 %h", ov[0], y[0], 128'h1);
    end
    handshake(0);
    accept(1, '1, '1);
    wait_done(1, 40, e, sr);
    checks++;
    if (ov[1] !== 1'b1 || e != 17) begin
      failures++;
      $display("FAIL ones_full_latency: out_valid=%b edges=%0d, want 1 after 17", ov[1], e);
    end
    checks++;
    if (y[1] !== exp_full) begin
      failures++;
      $display("FAIL ones_full_Y: got %h want %h", y[1], exp_full);
    end
    handshake(1);
  endtask

  task automatic test_limb_order(input int d, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] exp_q[$];
    int e; bit sr;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (d == 1 || i + j <= 3) exp_q.push_back({a[16*i +: 16], b[16*j +: 16]});
    accept(d, a, b);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      checks++;
      if ({ma[d], mb[d]} !== exp_q[k]) begin
        failures++;
        $display("FAIL limb_order[%0d] step %0d: (mul_a,mul_b)=(%h,%h) want (%h,%h)",
                 d, k + 1, ma[d], mb[d], exp_q[k][31:16], exp_q[k][15:0]);
      end
    end
    wait_done(d, 40, e, sr);
    checks++;
    if (ov[d] !== 1'b1 || y[d] !== ref_prod(a, b, d == 1) || ma[d] !== '0 || mb[d] !== '0) begin
      failures++;
      $display("FAIL limb_result[%0d]: out_valid=%b Y=%h mul=%h/%h want 1 %h 0/0",
               d, ov[d], y[d], ma[d], mb[d], ref_prod(a, b, d == 1));
    end
    handshake(d);
  endtask

  task automatic test_random();
    int e; bit sr;
    logic [63:0] a, b;
    for (int n = 0; n < 8; n++) begin
      int d;
      d = n % 2;
      a = rnd64();
      b = (n == 2) ? 64'hFFFF_FFFF_FFFF_FFFD : rnd64();
      accept(d, a, b);
      a_in[d] = rnd64();
      b_in[d] = rnd64();
      wait_done(d, 40, e, sr);
      checks++;
      if (ov[d] !== 1'b1 || y[d] !== ref_prod(a, b, d == 1)) begin
        failures++;
        $display("FAIL random[%0d] inst %0d: out_valid=%b Y=%h want %h", n, d, ov[d], y[d],
                 ref_prod(a, b, d == 1));
      end
      handshake(d);
    end
  endtask

  task automatic test_stall();
    int e; bit sr;
    logic [63:0] a, b, na, nb;
    a = rnd64(); b = rnd64(); na = rnd64(); nb = rnd64();
    accept(0, a, b);
    wait_done(0, 30, e, sr);
    a_in[0] = na;
    b_in[0] = nb;
    iv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || irdy[0] !== 1'b0 || y[0] !== ref_prod(a, b, 1'b0)) begin
        failures++;
        $display("FAIL stall cycle %0d: out_valid=%b in_ready=%b Y=%h want 1 0 %h",
                 k, ov[0], irdy[0], y[0], ref_prod(a, b, 1'b0));
      end
    end
    handshake(0);
    @(negedge clk);
    checks++;
    if (irdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle: in_ready=%b out_valid=%b want 1 0", irdy[0], ov[0]);
    end
    @(posedge clk);
    #1 iv[0] = 1'b0;
    checks++;
    if (irdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL stall_reaccept: in_ready=%b want 0", irdy[0]);
    end
    wait_done(0, 30, e, sr);
    checks++;
    if (ov[0] !== 1'b1 || e != 11 || y[0] !== ref_prod(na, nb, 1'b0)) begin
      failures++;
      $display("FAIL stall_next: out_valid=%b edges=%0d Y=%h want 1 11 %h",
               ov[0], e, y[0], ref_prod(na, nb, 1'b0));
    end
    handshake(0);
  endtask

  task automatic test_abort();
    int e; bit sr; bit leaked;
    accept(0, rnd64(), rnd64());
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b1 || ma[0] !== '0 || mb[0] !== '0 || y[0] !== '0) begin
      failures++;
      $display("FAIL abort_async: out_valid=%b in_ready=%b mul=%h/%h Y=%h want 0 1 0/0 0",
               ov[0], irdy[0], ma[0], mb[0], y[0]);
    end
    @(negedge clk);
    arst = 1'b0;
    leaked = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      failures++;
      $display("FAIL abort_no_result: activity after reset, want idle");
    end
    accept(0, 64'd7, 64'd9);
    wait_done(0, 30, e, sr);
    checks++;
    if (ov[0] !== 1'b1 || y[0] !== 128'd63) begin
      failures++;
      $display("FAIL abort_next: out_valid=%b Y=%h want 1 %h", ov[0], y[0], 128'd63);
    end
    handshake(0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] oa[3], ob[3];
    int acc_edge[3];
    int n;
    for (int k = 0; k < 3; k++) begin
      oa[k] = rnd64();
      ob[k] = rnd64();
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    a_in[0] = oa[0];
    b_in[0] = ob[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (irdy[0] !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1 acc_edge[k] = edge_cnt;
      if (k < 2) begin
        a_in[0] = oa[k + 1];
        b_in[0] = ob[k + 1];
      end else begin
        iv[0] = 1'b0;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (ov[0] !== 1'b1 && n < 60);
      checks++;
      if (ov[0] !== 1'b1 || y[0] !== ref_prod(oa[k], ob[k], 1'b0)) begin
        failures++;
        $display("FAIL b2b_Y[%0d]: out_valid=%b Y=%h want 1 %h", k, ov[0], y[0],
                 ref_prod(oa[k], ob[k], 1'b0));
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (acc_edge[k] - acc_edge[k - 1] != 13) begin
        failures++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 13", k, acc_edge[k] - acc_edge[k - 1]);
      end
    end
    @(posedge clk);
    #1 ordy[0] = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    iv   = '0;
    ordy = '0;
    for (int d = 0; d < 2; d++) begin
      a_in[d] = '0;
      b_in[d] = '0;
    end
    test_reset();
    test_basic();
    test_all_ones();
    test_limb_order(0, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005);
    test_limb_order(1, rnd64(), rnd64());
    test_random();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/v2f_mul64_seq.md
# v2f_mul64_seq

Sequential 64×64 multiplier controller that time-shares one external 16×16→32 unsigned multiplier, the same limb decomposition the 64-bit `$mul` narrowing produces spatially. It latches operands on a valid/ready handshake and issues one 16-bit limb pair per cycle to the shared multiplier. It shifts and accumulates the partial products and returns the product on a valid/ready output. It replaces up to 16 parallel multiplier combinators with one when throughput is not critical.

## Interface
- `LOW_ONLY`, default 1: 1 = compute only Y[63:0] (partial products with i+j≤3, 10 steps); 0 = full 128-bit unsigned product (16 steps).
- `CLK` in 1: clock, rising edge.
- `ARST` in 1: reset; one clock; reset is asynchronous and active-high.
- `in_valid` in 1: operand request.
- `in_ready` out 1: controller can accept operands.
- `A` in 64: multiplicand, sampled on accept.
- `B` in 64: multiplier, sampled on accept.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts result.
- `Y` out 128: product; Y[127:64]=0 when LOW_ONLY=1.
- `mul_a` out 16: limb to the shared multiplier.
- `mul_b` out 16: limb to the shared multiplier.
- `mul_p` in 32: combinational product mul_a*mul_b, same cycle.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch A, B; clear acc; step=0; go to CALC.
- CALC: limb indices (i,j) follow the order i=0..3 outer, j=0..3 inner. When LOW_ONLY=1, pairs with i+j>3 are skipped.
  - Each cycle: mul_a=A_lat[16i+15:16i], mul_b=B_lat[16j+15:16j], acc ← acc + ({96'b0,mul_p} << 16(i+j)), mod 2^128.
  - On the last step, go to DONE.
- DONE: out_valid=1 and Y=acc (LOW_ONLY=1: acc[127:64] forced to 0). On out_ready, go to IDLE.
- mul_a and mul_b are 0 outside CALC.
- A and B changes after accept are ignored.
- Signedness: Y[63:0] is correct for signed and unsigned operands. Y[127:64] is an unsigned-only result.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, Y=0, mul_a=0, mul_b=0, acc=0.
- Accept at edge 0. CALC occupies cycles 1..N (N=10 for LOW_ONLY=1, N=16 otherwise). out_valid rises at cycle N+1.
- in_ready=0 in CALC and DONE. The earliest next accept is the cycle after the out handshake, because IDLE lasts at least one cycle. No pipelined overlap.
- out_valid stays high and Y stays stable until out_ready is seen. out_ready while not DONE is ignored.
- ARST mid-CALC or mid-DONE: the operation is aborted, outputs return to reset values asynchronously, and no result is emitted.
- in_valid and out_ready asserted together in DONE: only the output handshake completes. The input waits.

## Structure
- Package `v2f_mul_pkg`:
  - State enum.
  - `LIMB_W=16`, `NUM_LIMBS=4`.
  - `STEPS_LOW=10`, `STEPS_FULL=16`.
- Sub-module `v2f_mul_limb_sched`: step counter producing i, j, the shift amount 16(i+j), and `last`. Applies the LOW_ONLY skip. Has start/advance inputs.
- The multiplier is external so multiple controllers or other users can share it under a higher-level arbiter.

## Test plan
- A=3, B=5, LOW_ONLY=1 -> Y=15, out_valid exactly 11 cycles after the accept edge, in_ready=0 throughout.
- A=B=64'hFFFF_FFFF_FFFF_FFFF:
  - LOW_ONLY=1 -> Y=128'h1.
  - LOW_ONLY=0 -> Y=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, after 17 cycles.
- A=64'h0004_0003_0002_0001, B=64'h0008_0007_0006_0005, LOW_ONLY=1 -> (mul_a,mul_b) on cycles 1..10 = (1,5),(1,6),(1,7),(1,8),(2,5),(2,6),(2,7),(3,5),(3,6),(4,5).
- out_ready low for 5 cycles in DONE, in_valid high with new operands -> Y stable, in_ready=0, new operands not latched. After out_ready, IDLE one cycle, then accept.
- ARST pulse during CALC step 4 -> out_valid=0, in_ready=1 immediately. A following A=7, B=9 -> Y=63.
- in_valid held high for 3 operations -> each result correct. Accepts spaced N+3 cycles apart with out_ready=1.
